// File: rtl/tk_sink_buffer.sv
// Token sink: terminates a forward-token stream into a circular FIFO, drives the
// registered backward nack upstream and exposes the head entry to a local consumer.
package tk_sink_buffer_pkg;
  typedef struct packed {
    logic        v;
    logic        a;
    logic        c;
    logic        r;
    logic        i;
    logic [31:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module tk_sink_buffer
  import tk_sink_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SLACK = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  FTk_t                     I_FTk,
  output BTk_t                     O_BTk,
  input  BTk_t                     I_BTk,
  input  logic                     I_Pop,
  output FTk_t                     O_FTk,
  output logic [$clog2(DEPTH):0]   O_Count,
  output logic                     O_Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - SLACK);

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("tk_sink_buffer: DEPTH must be a power of two >= 4");
    end
    if ((SLACK < 1) || (SLACK >= DEPTH)) begin : g_bad_slack
      $error("tk_sink_buffer: SLACK must satisfy 1 <= SLACK < DEPTH");
    end
  endgenerate

  typedef struct packed {
    logic        a;
    logic        c;
    logic        r;
    logic        i;
    logic [31:0] d;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            nack_q, nack_d;
  logic            ovf_q, ovf_d;
  logic [2:0]      bpass_q, bpass_d;
  logic            push, pop, full, empty;
  entry_t          head;

  // The consumer's nack bit has no meaning at a sink; only t/v/c are forwarded.
  logic unused_btk_n;
  assign unused_btk_n = I_BTk.n;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  always_comb begin
    pop      = I_Pop && !empty;
    // A full buffer still accepts a token when the head leaves in the same cycle.
    push     = I_FTk.v && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    nack_d   = (count_d >= THRESH_C);
    ovf_d    = ovf_q || (I_FTk.v && full && !pop);
    bpass_d  = {I_BTk.t, I_BTk.v, I_BTk.c};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      nack_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bpass_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      nack_q   <= nack_d;
      ovf_q    <= ovf_d;
      bpass_q  <= bpass_d;
    end
  end

  // Storage is intentionally not reset; the head payload is masked by v while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: I_FTk.a, c: I_FTk.c, r: I_FTk.r, i: I_FTk.i, d: I_FTk.d};
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    O_FTk   = '{v: !empty, a: head.a, c: head.c, r: head.r, i: head.i, d: head.d};
    O_BTk   = '{n: nack_q, t: bpass_q[2], v: bpass_q[1], c: bpass_q[0]};
  end

  assign O_Count    = count_q;
  assign O_Overflow = ovf_q;

endmodule

// File: tb/tb_tk_sink_buffer.sv
// Directed bench for tk_sink_buffer: reset, latency, nack threshold, overflow,
// full push+pop, and a wrapping stream with random pops plus backward pass-through.
module tb_tk_sink_buffer;
  import tk_sink_buffer_pkg::*;

  logic        clock;
  logic        reset;
  FTk_t        I_FTk;
  BTk_t        O_BTk;
  BTk_t        I_BTk;
  logic        I_Pop;
  FTk_t        O_FTk;
  logic [3:0]  O_Count;
  logic        O_Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  tk_sink_buffer #(.DEPTH(8), .SLACK(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .I_FTk      (I_FTk),
    .O_BTk      (O_BTk),
    .I_BTk      (I_BTk),
    .I_Pop      (I_Pop),
    .O_FTk      (O_FTk),
    .O_Count    (O_Count),
    .O_Overflow (O_Overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_tok(input logic [31:0] d);
    I_FTk   = '0;
    I_FTk.v = 1'b1;
    I_FTk.d = d;
    tick();
    I_FTk   = '0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp_d);
    I_Pop = 1'b1;
    check_eq(tag, O_FTk.d, exp_d);
    tick();
    I_Pop = 1'b0;
  endtask

  int sent, got;

  initial begin
    reset = 1'b1;
    I_FTk = '0;
    I_BTk = '0;
    I_Pop = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset then idle, including pops on empty
    check_eq("rst_v", O_FTk.v, 0);
    check_eq("rst_btk", O_BTk, 0);
    check_eq("rst_count", O_Count, 0);
    check_eq("rst_ovf", O_Overflow, 0);
    I_Pop = 1'b1;
    tick(); tick(); tick();
    I_Pop = 1'b0;
    check_eq("emptypop_v", O_FTk.v, 0);
    check_eq("emptypop_count", O_Count, 0);
    check_eq("emptypop_btk", O_BTk, 0);

    // Single token with one-cycle latency
    I_FTk   = '0;
    I_FTk.v = 1'b1;
    I_FTk.a = 1'b1;
    I_FTk.d = 32'hDEADBEEF;
    tick();
    I_FTk = '0;
    check_eq("single_v", O_FTk.v, 1);
    check_eq("single_d", O_FTk.d, 32'hDEADBEEF);
    check_eq("single_a", O_FTk.a, 1);
    check_eq("single_count", O_Count, 1);
    I_Pop = 1'b1;
    tick();
    I_Pop = 1'b0;
    check_eq("single_pop_v", O_FTk.v, 0);
    check_eq("single_pop_count", O_Count, 0);

    // Nack threshold at DEPTH-SLACK = 6
    for (int i = 1; i <= 6; i++) begin
      push_tok(i);
      if (i == 5) check_eq("nack_at5", O_BTk.n, 0);
    end
    check_eq("nack_at6", O_BTk.n, 1);
    check_eq("nack_count6", O_Count, 6);
    push_tok(7);
    push_tok(8);
    check_eq("slack_count8", O_Count, 8);
    check_eq("slack_ovf", O_Overflow, 0);
    pop_chk("nack_pop_d1", 1);
    check_eq("nack_count7", O_Count, 7);
    check_eq("nack_n7", O_BTk.n, 1);
    pop_chk("nack_pop_d2", 2);
    check_eq("nack_n6", O_BTk.n, 1);
    pop_chk("nack_pop_d3", 3);
    check_eq("nack_count5", O_Count, 5);
    check_eq("nack_n5", O_BTk.n, 0);
    for (int k = 4; k <= 8; k++) pop_chk("nack_drain_d", k);
    check_eq("nack_drained_v", O_FTk.v, 0);

    // Overflow: 9th token dropped, flag sticky
    for (int i = 1; i <= 8; i++) push_tok(i);
    push_tok(9);
    check_eq("ovf_count", O_Count, 8);
    check_eq("ovf_flag", O_Overflow, 1);
    for (int k = 1; k <= 8; k++) pop_chk("ovf_order_d", k);
    check_eq("ovf_empty_v", O_FTk.v, 0);
    check_eq("ovf_empty_count", O_Count, 0);
    check_eq("ovf_sticky", O_Overflow, 1);

    // Asynchronous reset clears the flag without a clock edge
    reset = 1'b1;
    #1;
    check_eq("async_rst_ovf", O_Overflow, 0);
    check_eq("async_rst_count", O_Count, 0);
    tick();
    reset = 1'b0;
    tick();

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_tok(32'h10 + i);
    I_FTk   = '0;
    I_FTk.v = 1'b1;
    I_FTk.d = 32'h55;
    pop_chk("fullpp_head", 32'h10);
    I_FTk = '0;
    check_eq("fullpp_count", O_Count, 8);
    check_eq("fullpp_ovf", O_Overflow, 0);
    for (int k = 1; k < 8; k++) pop_chk("fullpp_order", 32'h10 + k);
    pop_chk("fullpp_last", 32'h55);
    check_eq("fullpp_empty", O_Count, 0);

    // Wrapping stream with random pops, honouring nack; backward pass-through
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      I_FTk   = '0;
      I_FTk.v = (sent < 20) && !O_BTk.n;
      I_FTk.d = sent;
      I_Pop   = 1'($urandom_range(0, 1));
      if (I_Pop && O_FTk.v) begin
        check_eq("stream_d", O_FTk.d, got);
        got++;
      end
      I_BTk = (cyc == 7) ? '{n: 1'b0, t: 1'b1, v: 1'b1, c: 1'b1} : '0;
      tick();
      if (I_FTk.v) sent++;
      if (cyc == 7) begin
        check_eq("bpass_t", O_BTk.t, 1);
        check_eq("bpass_vc", {O_BTk.v, O_BTk.c}, 2'b11);
      end
      if (cyc == 8) check_eq("bpass_t_clear", O_BTk.t, 0);
    end
    I_FTk = '0;
    I_Pop = 1'b0;
    I_BTk = '0;
    check_eq("stream_all", got, 20);
    check_eq("stream_ovf", O_Overflow, 0);
    check_eq("stream_count", O_Count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tk_sink_buffer.md
Name: tk_sink_buffer

Overview:
- Receiving endpoint of the valid/nack token protocol: terminates a forward-token stream (FTk_t) arriving from a retiming chain.
- Buffers incoming tokens in a circular FIFO.
- Generates the backward nack that throttles the upstream chain.
- Presents buffered tokens to a local consumer through a simple valid/pop interface. Sits at compute-element inputs and at stream sinks (memory write ports).

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- SLACK, 2, entries reserved for in-flight tokens after nack asserts (covers the registered nack plus one capture register upstream); 1 <= SLACK < DEPTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- I_FTk  in  FTk_t  upstream forward tokens (v, a, c, r, i, d).
- O_BTk  out  BTk_t  backward tokens to upstream (n, t, v, c).
- I_BTk  in  BTk_t  backward tokens from local consumer; only t, v, c used.
- I_Pop  in  1  local consumer takes head entry this cycle.
- O_FTk  out  FTk_t  head entry; .v = buffer non-empty.
- O_Count  out  $clog2(DEPTH)+1  current occupancy.
- O_Overflow  out  1  sticky: a token was dropped.

Behaviour:
- Reset (async, active-high): write ptr = 0, read ptr = 0, count = 0, O_BTk all fields 0, O_Overflow = 0, O_FTk.v = 0. Storage array is not reset; O_FTk payload fields are don't-care while .v = 0.
- Push condition: I_FTk.v = 1 and count < DEPTH, or count = DEPTH with a pop in the same cycle. On push, store a, c, r, i, d at the write ptr and increment it modulo DEPTH (natural wrap).
- Pop condition: I_Pop = 1 and count > 0. On pop, increment the read ptr modulo DEPTH. I_Pop while empty is ignored; no pointer or count change.
- Simultaneous push and pop: count unchanged; both pointers advance. At count = 1, the head is replaced by the new token on the next cycle.
- Count arithmetic: count_next = count + push - pop, held in $clog2(DEPTH)+1 bits and never exceeding DEPTH.
- Drop case: I_FTk.v = 1, count = DEPTH and no pop → token dropped, O_Overflow set. O_Overflow stays set until reset.
- Output latency: O_FTk is combinational from the head entry. A token pushed into an empty buffer in cycle N appears with O_FTk.v = 1 in cycle N+1 (1-cycle latency).
- Nack: registered. O_BTk.n <= (count_next >= DEPTH - SLACK), so it asserts the cycle after occupancy reaches the threshold and deasserts the cycle after occupancy falls below it. Upstream may keep delivering up to SLACK tokens after nack is seen; all of them must be accepted without overflow.
- Backward pass-through: O_BTk.t/v/c <= I_BTk.t/v/c, 1-cycle register, 0 at reset.
- Reset mid-stream: contents discarded, count = 0, nack and overflow cleared immediately (asynchronous).
- Valid tokens arriving while nack = 1 are accepted normally; nack is advisory and space is guaranteed by SLACK.

Test Plan:
- Reset then idle: O_FTk.v = 0, O_BTk = 0, O_Count = 0, O_Overflow = 0; after 3 pops on empty, still all 0.
- Single token d = 32'hDEADBEEF, a = 1 pushed in cycle 5 → cycle 6: O_FTk.v = 1, O_FTk.d = 32'hDEADBEEF, a = 1, O_Count = 1; pop in cycle 6 → cycle 7: O_FTk.v = 0, O_Count = 0.
- Nack threshold (DEPTH = 8, SLACK = 2): push 6 tokens back-to-back, no pops → O_BTk.n = 1 the cycle after the 6th push. Push 2 more → O_Count = 8, O_Overflow = 0. One pop → count 7, n stays 1. Pops down to 5 → n = 0 next cycle.
- Overflow: fill to 8, push a 9th with no pop → O_Count = 8, O_Overflow = 1, stays 1 after draining. Data order is tokens 1..8, token 9 absent.
- Full with simultaneous push and pop: at count = 8, push d = 0x55 while popping → O_Count = 8, O_Overflow = 0, 0x55 read out last.
- Wrap and pass-through: stream 20 tokens d = 0..19 with random I_Pop (50%) → output order 0..19, no loss, pointers wrap cleanly. I_BTk.t = 1 in cycle k → O_BTk.t = 1 in cycle k+1.
